// File: rtl/key_event_unit.sv
`default_nettype none
// ============================================================================
//  Module   : key_event_unit
//  Purpose  : Multi-channel key front end. Synchronises and debounces
//             NUM_KEYS raw switches and queues {key index, event type}
//             records in a small valid/ready FIFO.
//             Optional long-press events are enabled by defining the
//             macro KEY_EVENT_LONG_PRESS_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module key_event_unit #(
  parameter int CLOCK_HZ           = 12_000_000,
  parameter int NUM_KEYS           = 8,
  parameter int FILTER_HZ          = 10000,
  parameter int FILTER_COUNTER_MAX = 3,
  parameter int FIFO_DEPTH         = 4,
  parameter int LONG_PRESS_MS      = 500,
  parameter int ACTIVE_LOW         = 1,
  localparam int KEY_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] async_in,
  output logic [NUM_KEYS-1:0] key_state,
  output logic                event_valid,
  input  logic                event_ready,
  output logic [KEY_W-1:0]    event_key,
  output logic [1:0]          event_type,
  output logic                overflow,
  input  logic                clear_overflow
);

  localparam int DIV    = CLOCK_HZ / FILTER_HZ;
  localparam int PRE_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CNT_W  = (FILTER_COUNTER_MAX > 0) ? $clog2(FILTER_COUNTER_MAX + 1) : 1;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCNT_W = PTR_W + 1;
  localparam int ENT_W  = KEY_W + 2;

  // Elaboration-time parameter sanity checks. The tick ratio check is what
  // lets every pending bit drain between two debounce ticks.
  generate
    if (NUM_KEYS < 1 || NUM_KEYS > 32) begin : g_chk_num_keys
      $error("key_event_unit: NUM_KEYS must be 1..32");
    end
    if (FILTER_COUNTER_MAX < 1) begin : g_chk_filter
      $error("key_event_unit: FILTER_COUNTER_MAX must be >= 1");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
      $error("key_event_unit: FIFO_DEPTH must be a power of two >= 2");
    end
    if (DIV < 2 * NUM_KEYS + 2) begin : g_chk_ratio
      $error("key_event_unit: CLOCK_HZ/FILTER_HZ must be >= 2*NUM_KEYS+2");
    end
    if (LONG_PRESS_MS < 0) begin : g_chk_long
      $error("key_event_unit: LONG_PRESS_MS must be >= 0");
    end
  endgenerate

  logic [NUM_KEYS-1:0]            raw_pressed;
  logic [NUM_KEYS-1:0]            sync1_q, sync2_q;
  logic [PRE_W-1:0]               presc_q, presc_d;
  logic                           tick;
  logic [NUM_KEYS-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_KEYS-1:0]            key_q, key_d;
  logic [NUM_KEYS-1:0]            toggle;
  logic [NUM_KEYS-1:0]            pend_edge_q, pend_edge_d;
  logic [NUM_KEYS-1:0]            pend_long_q, pend_long_d;
  logic [NUM_KEYS-1:0]            set_long;
  logic [NUM_KEYS-1:0]            clr_edge, clr_long;
  logic                           push;
  logic [KEY_W-1:0]               push_key;
  logic [1:0]                     push_type;
  logic [FIFO_DEPTH-1:0][ENT_W-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]               wr_q, wr_d, rd_q, rd_d;
  logic [FCNT_W-1:0]              count_q, count_d;
  logic                           valid_q, valid_d;
  logic                           ovf_q, ovf_d;
  logic                           pop, full, do_push;

  assign raw_pressed = (ACTIVE_LOW != 0) ? ~async_in : async_in;
  assign tick        = (presc_q == PRE_W'(DIV - 1));

  // Prescaler and per-channel debounce counters; toggles fire only on tick.
  always_comb begin
    presc_d = tick ? '0 : presc_q + 1'b1;
    key_d   = key_q;
    cnt_d   = cnt_q;
    toggle  = '0;
    if (tick) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (sync2_q[i] == key_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_W'(FILTER_COUNTER_MAX - 1)) begin
          cnt_d[i]  = '0;
          key_d[i]  = ~key_q[i];
          toggle[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

`ifdef KEY_EVENT_LONG_PRESS_EN
  localparam int LONG_RAW   = LONG_PRESS_MS * FILTER_HZ / 1000;
  localparam int LONG_TICKS = (LONG_RAW < 1) ? 1 : LONG_RAW;
  localparam int HOLD_W     = $clog2(LONG_TICKS + 1);

  logic [NUM_KEYS-1:0][HOLD_W-1:0] hold_q, hold_d;
  logic [NUM_KEYS-1:0]             fired_q, fired_d;

  // Saturating hold timers; a long event fires once per press.
  always_comb begin
    hold_d   = hold_q;
    fired_d  = fired_q;
    set_long = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (!key_q[i]) begin
        hold_d[i]  = '0;
        fired_d[i] = 1'b0;
      end else if (tick && hold_q[i] != HOLD_W'(LONG_TICKS)) begin
        hold_d[i] = hold_q[i] + 1'b1;
        if (hold_q[i] == HOLD_W'(LONG_TICKS - 1) && !fired_q[i]) begin
          set_long[i] = 1'b1;
          fired_d[i]  = 1'b1;
        end
      end
    end
  end

  // Hold timer registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      hold_q  <= '0;
      fired_q <= '0;
    end else begin
      hold_q  <= hold_d;
      fired_q <= fired_d;
    end
  end
`else
  assign set_long = '0;
`endif

  // Serialiser: lowest channel first, edge before long, one push per clock.
  always_comb begin
    push      = 1'b0;
    push_key  = '0;
    push_type = 2'b00;
    clr_edge  = '0;
    clr_long  = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (!push) begin
        if (pend_edge_q[i]) begin
          push        = 1'b1;
          push_key    = KEY_W'(i);
          push_type   = {1'b0, key_q[i]};
          clr_edge[i] = 1'b1;
        end else if (pend_long_q[i]) begin
          push        = 1'b1;
          push_key    = KEY_W'(i);
          push_type   = 2'b10;
          clr_long[i] = 1'b1;
        end
      end
    end
    pend_edge_d = (pend_edge_q & ~clr_edge) | toggle;
    pend_long_d = (pend_long_q & ~clr_long) | set_long;
  end

  // Event FIFO with sticky overflow; a pop frees room for a same-cycle push.
  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    pop     = valid_q && event_ready;
    full    = (count_q == FCNT_W'(FIFO_DEPTH));
    do_push = push && (!full || pop);
    if (do_push) begin
      mem_d[wr_q] = {push_key, push_type};
      wr_d        = wr_q + 1'b1;
    end
    if (pop) begin
      rd_d = rd_q + 1'b1;
    end
    case ({do_push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    valid_d = (count_d != '0);
    if (clear_overflow) begin
      ovf_d = 1'b0;
    end
    if (push && full && !pop) begin
      ovf_d = 1'b1;
    end
  end

  // State registers for synchroniser, debounce, pending bits and FIFO.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      presc_q     <= '0;
      cnt_q       <= '0;
      key_q       <= '0;
      pend_edge_q <= '0;
      pend_long_q <= '0;
      mem_q       <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      count_q     <= '0;
      valid_q     <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      sync1_q     <= raw_pressed;
      sync2_q     <= sync1_q;
      presc_q     <= presc_d;
      cnt_q       <= cnt_d;
      key_q       <= key_d;
      pend_edge_q <= pend_edge_d;
      pend_long_q <= pend_long_d;
      mem_q       <= mem_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      count_q     <= count_d;
      valid_q     <= valid_d;
      ovf_q       <= ovf_d;
    end
  end

  assign key_state               = key_q;
  assign event_valid             = valid_q;
  assign {event_key, event_type} = mem_q[rd_q];
  assign overflow                = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_key_event_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_key_event_unit
//  Purpose  : Self-checking bench for key_event_unit with a scoreboard of
//             expected {key, type} events popped as the DUT hands them out.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_key_event_unit;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] async_in;
  logic [3:0] key_state;
  logic       event_valid;
  logic       event_ready;
  logic [1:0] event_key;
  logic [1:0] event_type;
  logic       overflow;
  logic       clear_overflow;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  logic [3:0] sb[$];
  int         pop_cyc[$];

  key_event_unit #(
    .CLOCK_HZ(1000), .NUM_KEYS(4), .FILTER_HZ(100), .FILTER_COUNTER_MAX(3),
    .FIFO_DEPTH(4), .LONG_PRESS_MS(50), .ACTIVE_LOW(1)
  ) dut (
    .clock(clock), .reset(reset), .async_in(async_in), .key_state(key_state),
    .event_valid(event_valid), .event_ready(event_ready), .event_key(event_key),
    .event_type(event_type), .overflow(overflow), .clear_overflow(clear_overflow)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every accepted head must match the oldest expectation.
  always @(negedge clock) begin
    if (!reset && event_valid && event_ready) begin
      pop_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        check_eq("unexpected_event", sb.size(), 1);
      end else begin
        check_eq("event", {28'd0, event_key, event_type}, {28'd0, sb.pop_front()});
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic expect_ev(input logic [1:0] k, input logic [1:0] t);
    sb.push_back({k, t});
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200 && sb.size() != 0; i++) step(1);
    step(2);
    check_eq(tag, sb.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    async_in       = 4'hF;
    event_ready    = 1'b1;
    clear_overflow = 1'b0;
    step(3);
    reset = 1'b0;
    check_eq("rst_key_state", key_state, 0);
    check_eq("rst_valid", event_valid, 0);
    check_eq("rst_overflow", overflow, 0);
    check_eq("rst_head", {event_key, event_type}, 0);

    // 1: idle released keys for 50 ticks
    step(500);
    check_eq("idle_key_state", key_state, 0);
    check_eq("idle_overflow", overflow, 0);

    // 2: single press and release of key 2
    async_in[2] = 1'b0;
    expect_ev(2'd2, 2'b01);
    step(20);
    check_eq("k2_not_yet", key_state[2], 0);
    step(15);
    check_eq("k2_pressed", key_state[2], 1);
    drain("k2_press_drain");
    async_in[2] = 1'b1;
    expect_ev(2'd2, 2'b00);
    step(40);
    check_eq("k2_released", key_state[2], 0);
    drain("k2_release_drain");

    // 3: bouncing key 1, then settles pressed
    for (int i = 0; i < 10; i++) begin
      async_in[1] = ~async_in[1];
      step(10);
    end
    check_eq("bounce_no_press", key_state[1], 0);
    async_in[1] = 1'b0;
    expect_ev(2'd1, 2'b01);
    step(20);
    check_eq("bounce_not_yet", key_state[1], 0);
    step(15);
    check_eq("bounce_pressed", key_state[1], 1);
    drain("bounce_drain");
    async_in[1] = 1'b1;
    expect_ev(2'd1, 2'b00);
    step(40);
    drain("bounce_release_drain");

    // 4: keys 0 and 3 pressed together, delivered on consecutive cycles
    async_in[0] = 1'b0;
    async_in[3] = 1'b0;
    expect_ev(2'd0, 2'b01);
    expect_ev(2'd3, 2'b01);
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (event_valid) break;
    end
    check_eq("dual_first_key", event_key, 0);
    @(negedge clock);
    check_eq("dual_second_valid", event_valid, 1);
    check_eq("dual_second", {event_key, event_type}, {2'd3, 2'b01});
    step(1);
    drain("dual_drain");
    async_in[0] = 1'b1;
    async_in[3] = 1'b1;
    expect_ev(2'd0, 2'b00);
    expect_ev(2'd3, 2'b00);
    step(40);
    drain("dual_release_drain");

    // 5: fill FIFO with ready low, overflow, clear, drain, then reset flush
    event_ready = 1'b0;
    async_in    = 4'h0;
    for (int k = 0; k < 4; k++) expect_ev(k[1:0], 2'b01);
    step(40);
    check_eq("full_no_ovf", overflow, 0);
    check_eq("full_valid", event_valid, 1);
    async_in[0] = 1'b1;
    step(40);
    check_eq("drop_ovf", overflow, 1);
    check_eq("head_hold", {event_key, event_type}, {2'd0, 2'b01});
    clear_overflow = 1'b1;
    step(1);
    clear_overflow = 1'b0;
    check_eq("ovf_cleared", overflow, 0);
    event_ready = 1'b1;
    drain("ovf_drain");
    event_ready = 1'b0;
    async_in[2:1] = 2'b11;
    step(40);
    check_eq("queued_valid", event_valid, 1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check_eq("flush_valid", event_valid, 0);
    check_eq("flush_key_state", key_state, 0);
    expect_ev(2'd3, 2'b01);
    event_ready = 1'b1;
    step(40);
    drain("repress_drain");
    async_in[3] = 1'b1;
    expect_ev(2'd3, 2'b00);
    step(40);
    drain("k3_release_drain");

    // 6: hold key 0 for 20 ticks
    pop_cyc.delete();
    async_in[0] = 1'b0;
    expect_ev(2'd0, 2'b01);
`ifdef KEY_EVENT_LONG_PRESS_EN
    expect_ev(2'd0, 2'b10);
`endif
    step(200);
`ifdef KEY_EVENT_LONG_PRESS_EN
    check_eq("long_count", pop_cyc.size(), 2);
    if (pop_cyc.size() == 2) check_eq("long_delay", pop_cyc[1] - pop_cyc[0], 50);
`else
    check_eq("no_long_count", pop_cyc.size(), 1);
`endif
    async_in[0] = 1'b1;
    expect_ev(2'd0, 2'b00);
    step(40);
    drain("hold_release_drain");
    check_eq("final_overflow", overflow, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
